// File: rtl/arc4_key_search.sv
// Brute-force ARC4 key search: sweeps 24-bit keys through the arc4 core and
// snoops its plaintext writes, stopping at the first fully printable result.
module arc4_key_search #(
    parameter logic [23:0] KEY_FIRST = 24'h000000,
    parameter logic [23:0] KEY_LAST  = 24'hFFFFFF,
    parameter logic [7:0]  CHAR_LO   = 8'h20,
    parameter logic [7:0]  CHAR_HI   = 8'h7E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        a4_en,
    input  logic        a4_rdy,
    output logic        a4_rst_n,
    output logic [23:0] a4_key,
    input  logic        pt_wren,
    input  logic [7:0]  pt_addr,
    input  logic [7:0]  pt_wrdata
);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_BUSY, RUN, ABORT, NEXT, FOUND, FAIL
    } state_t;

    state_t     state;
    logic [1:0] busy_wait;
    logic       bad_write;

    // Address 0 carries the message length, so only the message bytes are screened.
    assign bad_write = pt_wren && (pt_addr != 8'd0) &&
                       ((pt_wrdata < CHAR_LO) || (pt_wrdata > CHAR_HI));

    // Start pulse is qualified by a4_rdy in the same cycle so a busy core never sees it.
    assign a4_en    = (state == LAUNCH) && a4_rdy;
    assign a4_rst_n = !rst && (state != ABORT);
    assign a4_key   = key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            key       <= KEY_FIRST;
            key_valid <= 1'b0;
            busy_wait <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state     <= LAUNCH;
                        rdy       <= 1'b0;
                        key       <= KEY_FIRST;
                        key_valid <= 1'b0;
                    end
                end
                LAUNCH: begin
                    if (a4_rdy) begin
                        state     <= WAIT_BUSY;
                        busy_wait <= 2'd0;
                    end
                end
                WAIT_BUSY: begin
                    // A core that never drops rdy missed the pulse; launch again.
                    if (!a4_rdy)
                        state <= RUN;
                    else if (busy_wait == 2'd3)
                        state <= LAUNCH;
                    else
                        busy_wait <= busy_wait + 2'd1;
                end
                RUN: begin
                    if (bad_write)
                        state <= ABORT;
                    else if (a4_rdy)
                        state <= FOUND;
                end
                ABORT: state <= NEXT;
                NEXT: begin
                    if (key == KEY_LAST) begin
                        state <= FAIL;
                    end else begin
                        key   <= key + 24'd1;
                        state <= LAUNCH;
                    end
                end
                FOUND: begin
                    key_valid <= 1'b1;
                    rdy       <= 1'b1;
                    state     <= IDLE;
                end
                FAIL: begin
                    key_valid <= 1'b0;
                    rdy       <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_key_search.sv
// Bench for arc4_key_search: a behavioural arc4 stand-in replays per-key
// plaintext tables; results are predicted by scanning the tables directly.
module tb_arc4_key_search;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        rdy, key_valid, a4_en, a4_rst_n;
    logic [23:0] key, a4_key;
    logic        a4_rdy, pt_wren;
    logic [7:0]  pt_addr, pt_wrdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arc4_key_search #(
        .KEY_FIRST(24'h000000), .KEY_LAST(24'h000003),
        .CHAR_LO(8'h20), .CHAR_HI(8'h7E)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
        .a4_en(a4_en), .a4_rdy(a4_rdy), .a4_rst_n(a4_rst_n), .a4_key(a4_key),
        .pt_wren(pt_wren), .pt_addr(pt_addr), .pt_wrdata(pt_wrdata)
    );

    // ---------------- arc4 stand-in ----------------
    logic [7:0] pt_tab [4][16];
    int         pt_len [4];
    bit         m_sim = 1'b0;     // raise rdy together with the final write
    logic [7:0] ct [16];

    logic       m_rdy = 1'b0, m_busy = 1'b0, m_wren = 1'b0;
    logic [7:0] m_addr = 8'd0, m_data = 8'd0;
    logic [1:0] m_k = 2'd0;
    int         m_idx = 0, m_rec = 3;

    assign a4_rdy    = m_rdy;
    assign pt_wren   = m_wren;
    assign pt_addr   = m_addr;
    assign pt_wrdata = m_data;

    always @(posedge clk) begin
        if (!a4_rst_n) begin
            m_rdy <= 1'b0; m_busy <= 1'b0; m_wren <= 1'b0; m_rec <= 3;
        end else if (m_rec > 0) begin
            m_rec <= m_rec - 1;
            m_rdy <= (m_rec == 1);
        end else if (!m_busy) begin
            m_wren <= 1'b0;
            if (a4_en && m_rdy) begin
                m_busy <= 1'b1; m_rdy <= 1'b0; m_k <= a4_key[1:0]; m_idx <= -2;
            end
        end else begin
            m_idx <= m_idx + 1;
            if (m_idx >= 0 && m_idx <= pt_len[m_k]) begin
                m_wren <= 1'b1; m_addr <= 8'(m_idx); m_data <= pt_tab[m_k][m_idx];
                if (m_idx == pt_len[m_k] && m_sim) begin m_rdy <= 1'b1; m_busy <= 1'b0; end
            end else begin
                m_wren <= 1'b0;
                if (m_idx > pt_len[m_k]) begin m_rdy <= 1'b1; m_busy <= 1'b0; end
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          cyc = 0, n_en = 0, n_rst_cyc = 0, n_rst_pulse = 0;
    int          viol_en = 0, viol_key = 0, lat_err = 0, n_lat = 0, bad_cyc = 0;
    bit          bad_pend = 1'b0, prev_rst_n = 1'b0;
    logic [23:0] en_keys [$];

    always @(negedge clk) begin
        if (rst) begin
            bad_pend   <= 1'b0;
            prev_rst_n <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (a4_en) begin
                n_en <= n_en + 1;
                en_keys.push_back(a4_key);
                if (!a4_rdy) viol_en <= viol_en + 1;
            end
            if (a4_key !== key) viol_key <= viol_key + 1;
            if (!a4_rst_n) begin
                n_rst_cyc <= n_rst_cyc + 1;
                if (prev_rst_n) n_rst_pulse <= n_rst_pulse + 1;
            end
            prev_rst_n <= a4_rst_n;
            if (a4_rst_n && pt_wren && pt_addr != 8'd0 &&
                (pt_wrdata < 8'h20 || pt_wrdata > 8'h7E) && !bad_pend) begin
                bad_pend <= 1'b1; bad_cyc <= cyc;
            end
            if (!a4_rst_n && bad_pend) begin
                bad_pend <= 1'b0;
                n_lat    <= n_lat + 1;
                if (cyc - bad_cyc != 1) lat_err <= lat_err + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_key(input int k, input int len, input logic [63:0] bytes);
        pt_len[k]    = len;
        pt_tab[k][0] = 8'(len);
        for (int n = 1; n <= len; n++) pt_tab[k][n] = bytes[8*(n-1) +: 8];
    endtask

    task automatic all_bad();
        for (int k = 0; k < 4; k++) set_key(k, 1, 64'h01);
    endtask

    // Table k becomes RC4(key=k) applied to ct[1..len].
    task automatic fill_rc4(input int len);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] tmp;
        int i, j, t;
        for (int k = 0; k < 4; k++) begin
            kb[0] = 8'h00; kb[1] = 8'h00; kb[2] = 8'(k);
            for (int a = 0; a < 256; a++) s[a] = 8'(a);
            j = 0;
            for (int a = 0; a < 256; a++) begin
                j = (j + s[a] + kb[a % 3]) % 256;
                tmp = s[a]; s[a] = s[j]; s[j] = tmp;
            end
            i = 0; j = 0;
            pt_len[k] = len; pt_tab[k][0] = 8'(len);
            for (int n = 1; n <= len; n++) begin
                i = (i + 1) % 256;
                j = (j + s[i]) % 256;
                tmp = s[i]; s[i] = s[j]; s[j] = tmp;
                t = (s[i] + s[j]) % 256;
                pt_tab[k][n] = ct[n] ^ s[t];
            end
        end
    endtask

    // First key in 0..3 whose message bytes are all printable.
    task automatic ref_search(output bit f, output int k_out, output int trials);
        bit ok;
        f = 1'b0; k_out = 3; trials = 0;
        for (int k = 0; k < 4; k++) begin
            trials++;
            ok = 1'b1;
            for (int n = 1; n <= pt_len[k]; n++)
                if (pt_tab[k][n] < 8'h20 || pt_tab[k][n] > 8'h7E) ok = 1'b0;
            if (ok) begin f = 1'b1; k_out = k; break; end
        end
    endtask

    task automatic wait_rdy(input string tag);
        int cnt = 0;
        while (!rdy && cnt < 3000) begin @(negedge clk); cnt++; end
        check(tag, rdy, 1'b1);
    endtask

    task automatic run_search(input bit mid_pulse);
        bit f;
        int k, tr, en0, rc0, rp0, q0;
        ref_search(f, k, tr);
        en0 = n_en; rc0 = n_rst_cyc; rp0 = n_rst_pulse; q0 = en_keys.size();
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        if (mid_pulse) begin
            repeat (3) @(negedge clk);
            en = 1'b1;
            @(negedge clk); en = 1'b0;
        end
        wait_rdy("search_done");
        check("result_valid", key_valid, f);
        check("result_key", key, k);
        check("launch_count", n_en - en0, tr);
        check("abort_pulses", n_rst_pulse - rp0, tr - int'(f));
        check("abort_width", n_rst_cyc - rc0, n_rst_pulse - rp0);
        if (en_keys.size() > q0) check("first_key", en_keys[q0], 0);
        else                     check("first_key_seen", 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int l0, cnt;
        rst = 1'b1; en = 1'b0;
        all_bad();
        repeat (2) @(negedge clk);
        check("rst_rdy", rdy, 1'b1);
        check("rst_key", key, 24'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_a4_en", a4_en, 1'b0);
        check("rst_a4_rst_n", a4_rst_n, 1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // "HI" encrypted under key 3, then decrypted under every candidate
        for (int n = 0; n < 16; n++) ct[n] = 8'h00;
        ct[1] = "H"; ct[2] = "I";
        fill_rc4(2);
        for (int n = 1; n <= 2; n++) ct[n] = pt_tab[3][n];
        fill_rc4(2);
        check("rc4_roundtrip", {pt_tab[3][1], pt_tab[3][2]}, {8'h48, 8'h49});
        run_search(1'b0);

        // random ciphertext: range almost surely exhausted
        for (int n = 1; n <= 8; n++) ct[n] = 8'($urandom);
        fill_rc4(8);
        run_search(1'b0);

        // inclusive printable bounds
        all_bad(); set_key(0, 2, 64'h7E_20);
        run_search(1'b0);

        // 0x1F just below range aborts one cycle later
        all_bad(); set_key(0, 3, 64'h41_41_1F); set_key(1, 1, 64'h41);
        l0 = n_lat;
        run_search(1'b0);
        check("abort_seen", n_lat - l0, 1);

        // empty message: only the length byte (0x00) is written
        all_bad(); set_key(0, 0, 64'h0);
        run_search(1'b0);

        // bad last byte together with rdy rising: abort wins
        m_sim = 1'b1;
        all_bad(); set_key(0, 5, 64'h7F_41_41_41_41); set_key(1, 2, 64'h42_41);
        l0 = n_lat;
        run_search(1'b0);
        check("simul_abort_seen", n_lat - l0, 1);
        m_sim = 1'b0;

        // en while busy is ignored
        all_bad(); set_key(2, 3, 64'h43_42_41);
        run_search(1'b1);

        // en held across completion restarts and clears key_valid
        all_bad(); set_key(0, 1, 64'h5A);
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        wait_rdy("held_done");
        check("held_valid", key_valid, 1'b1);
        check("held_key", key, 24'h0);
        @(negedge clk);
        check("held_restart_rdy", rdy, 1'b0);
        check("held_restart_valid", key_valid, 1'b0);
        en = 1'b0;
        wait_rdy("held_done2");
        check("held_valid2", key_valid, 1'b1);

        // reset in the middle of a candidate run
        for (int n = 1; n <= 12; n++) ct[n] = 8'($urandom);
        fill_rc4(12);
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        cnt = 0;
        while (!(pt_wren && a4_key != 24'h0 && !rdy) && cnt < 500) begin
            @(negedge clk); cnt++;
        end
        check("reached_run", cnt < 500, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_rdy", rdy, 1'b1);
        check("midrst_key", key, 24'h0);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_a4_rst_n", a4_rst_n, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        all_bad(); set_key(1, 2, 64'h21_7E);
        run_search(1'b0);

        // randomized tables, both rdy timings
        for (int r = 0; r < 6; r++) begin
            m_sim = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                pt_len[k] = $urandom_range(0, 5);
                pt_tab[k][0] = 8'(pt_len[k]);
                for (int n = 1; n <= pt_len[k]; n++)
                    pt_tab[k][n] = ($urandom_range(0, 5) == 0) ? 8'($urandom)
                                                               : 8'($urandom_range(32, 126));
            end
            run_search(1'b0);
        end
        m_sim = 1'b0;

        repeat (2) @(negedge clk);
        check("a4_en_only_when_rdy", viol_en, 0);
        check("a4_key_tracks_key", viol_key, 0);
        check("abort_latency", lat_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arc4_key_search.md
Name: arc4_key_search

Overview:
- Brute-force key search controller that sits directly upstream of the arc4 decryptor in the ARC4 datapath.
- Sweeps candidate 24-bit keys, launches arc4 once per key through arc4's rdy/en handshake, and snoops arc4's plaintext-memory write port.
- Aborts a candidate as soon as a non-printable byte is written.
- Reports the first key whose whole plaintext is printable, or reports failure once the key range is exhausted.

Parameters:
- KEY_FIRST, 24'h000000, first candidate key.
- KEY_LAST, 24'hFFFFFF, last candidate key (inclusive).
- CHAR_LO, 8'h20, lowest printable byte (inclusive).
- CHAR_HI, 8'h7E, highest printable byte (inclusive).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  out  24  current candidate key; final result when rdy=1.
- key_valid  out  1  high with rdy=1 when key decrypts to printable text.
- a4_en  out  1  one-cycle start pulse to arc4.
- a4_rdy  in  1  arc4 ready.
- a4_rst_n  out  1  active-low reset to arc4; used for abort.
- a4_key  out  24  key driven to arc4; always equals key.
- pt_wren  in  1  snooped arc4 plaintext write enable.
- pt_addr  in  8  snooped plaintext write address.
- pt_wrdata  in  8  snooped plaintext write data.

Behaviour:
- Reset values while rst=1:
  - state=IDLE, rdy=1, key=KEY_FIRST, key_valid=0, a4_en=0.
  - a4_rst_n=0, combinationally forced low for as long as rst=1.
- States and transitions:
  - IDLE: rdy=1.
    - en=1 → LAUNCH; load key=KEY_FIRST, clear key_valid; rdy=0 from the next cycle.
    - en while rdy=0 is ignored.
  - LAUNCH: hold a4_en=0 until a4_rdy=1; then assert a4_en=1 for exactly one cycle → WAIT_BUSY.
  - WAIT_BUSY: wait for a4_rdy=0 → RUN.
    - If a4_rdy is still 1 after 4 cycles → LAUNCH (retry).
  - RUN: check every cycle that has pt_wren=1.
    - pt_addr=0 is the length byte and is not checked.
    - pt_addr≥1 with pt_wrdata<CHAR_LO or >CHAR_HI → ABORT.
    - a4_rdy=1 with no bad byte → FOUND.
    - A bad write in the same cycle as a4_rdy rising → ABORT; the bad byte wins.
  - ABORT: drive a4_rst_n=0 for exactly one cycle → NEXT.
  - NEXT:
    - key==KEY_LAST → FAIL.
    - Otherwise key<=key+1 → LAUNCH; LAUNCH then waits for arc4 to re-assert a4_rdy after its reset.
  - FOUND: key_valid<=1 → IDLE; key holds the winning value.
  - FAIL: key_valid<=0 → IDLE; key holds KEY_LAST.
- Result retention: key and key_valid hold until the next accepted en, which clears key_valid in the same edge as leaving IDLE.
- Length-0 message: arc4 writes only address 0, so the first candidate is FOUND.
- Key arithmetic: 24-bit unsigned.
  - The increment never wraps, because KEY_LAST is checked before increment.
  - KEY_FIRST==KEY_LAST → exactly one trial.
- Outside RUN: snooped writes are ignored.
- a4_en: never asserted unless a4_rdy=1 in the same cycle.
- a4_rst_n: high except during rst or ABORT.
- Reset mid-search:
  - Returns to IDLE on the asynchronous edge.
  - a4_rst_n is held low so arc4 resets too.
  - No partial result is reported.
- Latency: en accepted → first a4_en ≥1 cycle later. Abort → next a4_en ≥3 cycles, plus arc4 recovery time.

Test Plan:
- Key-found path: arc4 model encrypts "HI" (len 2) under key 24'h000003; pulse en → ABORT for keys 0,1,2, then FOUND; rdy=1, key_valid=1, key=24'h000003. Check three one-cycle a4_rst_n=0 pulses.
- Exhausted range: KEY_FIRST=0, KEY_LAST=3, no key printable → rdy=1, key_valid=0, key=24'h000003, exactly 4 a4_en pulses.
- Boundary bytes: writes of 8'h20 and 8'h7E at addr 1,2 → accepted. Write of 8'h1F at addr 1 → ABORT the next cycle. Write of 8'h00 at addr 0 → not checked.
- Simultaneous events: bad byte 8'h7F at addr 5 in the same cycle a4_rdy rises → ABORT, key increments, no FOUND.
- Reset mid-operation: assert rst during RUN → immediately rdy=1, key=KEY_FIRST, key_valid=0, a4_rst_n=0. After release, en restarts from key 0.
- Handshake: en pulsed while rdy=0 → no effect. en held high across completion → new search starts and key_valid clears on that edge.
